// File: rtl/oam_arbiter_pkg.sv
// ============================================================================
// Module      : oam_arb_pkg
// Description : Shared types, constants and the halfword merge helper for the
//               OAM access arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package oam_arb_pkg;

    // OAM word address width (256 x 32-bit words)
    localparam int OAM_ADDR_W = 8;

    // Byte-enable patterns the OAM honours; anything else is dropped
    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_LO   = 4'h3;
    localparam logic [3:0] BE_HI   = 4'hC;

    // Arbiter states: IDLE arbitrates, RMW_WR completes a halfword write
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } arb_state_e;

    // Replace the enabled half of the stored word with the new data.
    // Non-halfword enables leave the old word untouched.
    function automatic logic [31:0] merge_half(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_w;
        if (be == BE_LO) begin
            res = {old_w[31:16], new_w[15:0]};
        end else if (be == BE_HI) begin
            res = {new_w[31:16], old_w[15:0]};
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/oam_arbiter_if.sv
// ============================================================================
// Module      : oam_arbiter_if
// Description : CPU, PPU and RAM-port signal bundle of the OAM arbiter.
//               'slave' is the arbiter's view, 'master' the surrounding
//               system (CPU bus, sprite engine and the OAM RAM).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface oam_arbiter_if
    import oam_arb_pkg::*;
#(
    parameter int ADDR_W = OAM_ADDR_W
);
    // CPU bus
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [3:0]        cpu_be;
    logic [31:0]       cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;

    // PPU sprite fetch
    logic              ppu_req;
    logic [ADDR_W-1:0] ppu_addr;
    logic              ppu_gnt;
    logic              ppu_rvalid;
    logic [31:0]       ppu_rdata;
    logic              ppu_active;

    // Single OAM RAM port (asynchronous read)
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  ppu_req, ppu_addr, ppu_active,
        output ppu_gnt, ppu_rvalid, ppu_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output ppu_req, ppu_addr, ppu_active,
        input  ppu_gnt, ppu_rvalid, ppu_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );

endinterface

`default_nettype wire

// File: rtl/oam_arbiter_starve_ctr.sv
// ============================================================================
// Module      : oam_starve_ctr
// Description : Saturating 8-bit CPU wait counter. Counts up on inc_i, clears
//               on clr_i (clear wins), flags when STARVE_MAX is reached.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oam_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  wire logic clk_i,
    input  wire logic rst_ni,
    input  wire logic inc_i,
    input  wire logic clr_i,
    output logic      limit_o
);

    localparam logic [7:0] LIMIT = 8'(STARVE_MAX);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear on grant, otherwise count waits up to the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (inc_i && (cnt_q < LIMIT)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_o = (cnt_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/oam_arbiter.sv
// ============================================================================
// Module      : oam_arbiter
// Description : Shares one OAM RAM port between the CPU bus and the PPU sprite
//               fetch engine. PPU wins during active display, CPU wins in
//               blanking, and a starvation guard forces a CPU win after
//               STARVE_MAX waiting cycles. Halfword CPU writes are done as
//               read-modify-write; other partial writes are dropped.
//               Optional feature macro: OAM_ARB_STATS_EN adds the stats_clr
//               input and the cpu_stall_cnt[15:0] output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oam_arbiter
    import oam_arb_pkg::*;
#(
    parameter int          ADDR_W     = OAM_ADDR_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  wire logic         clka,
    input  wire logic         rsta_n,
`ifdef OAM_ARB_STATS_EN
    input  wire logic         stats_clr,
    output logic [15:0]       cpu_stall_cnt,
`endif
    oam_arbiter_if.slave      bus
);

    arb_state_e        state_q;
    logic [ADDR_W-1:0] rmw_addr_q;
    logic [31:0]       rmw_data_q;
    logic              cpu_rvalid_q;
    logic [31:0]       cpu_rdata_q;
    logic              ppu_rvalid_q;
    logic [31:0]       ppu_rdata_q;

    logic              starve_lim;
    logic              cpu_gnt_w;
    logic              ppu_gnt_w;
    logic              cpu_stall;
    logic              cpu_full_wr;
    logic              cpu_half_wr;
    logic              cpu_rd;
    logic [ADDR_W-1:0] ram_addr_w;
    logic              ram_we_w;
    logic [31:0]       ram_wdata_w;

    // Starvation guard for the CPU
    oam_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk_i   (clka),
        .rst_ni  (rsta_n),
        .inc_i   (cpu_stall),
        .clr_i   (cpu_gnt_w),
        .limit_o (starve_lim)
    );

    // Single-winner arbitration; grants are suppressed while the RMW write
    // owns the port and while reset is held so outputs read as idle.
    always_comb begin
        cpu_gnt_w = 1'b0;
        ppu_gnt_w = 1'b0;
        if (rsta_n && (state_q == IDLE)) begin
            if (bus.cpu_req && (starve_lim || !bus.ppu_active || !bus.ppu_req)) begin
                cpu_gnt_w = 1'b1;
            end else if (bus.ppu_req) begin
                ppu_gnt_w = 1'b1;
            end
        end
    end

    assign cpu_stall   = bus.cpu_req && !cpu_gnt_w;
    assign cpu_rd      = cpu_gnt_w && !bus.cpu_we;
    assign cpu_full_wr = cpu_gnt_w && bus.cpu_we && (bus.cpu_be == BE_FULL);
    assign cpu_half_wr = cpu_gnt_w && bus.cpu_we &&
                         ((bus.cpu_be == BE_LO) || (bus.cpu_be == BE_HI));

    // RAM port steering: RMW write-back first, then the granted requester
    always_comb begin
        ram_addr_w  = '0;
        ram_we_w    = 1'b0;
        ram_wdata_w = 32'd0;
        if (rsta_n && (state_q == RMW_WR)) begin
            ram_addr_w  = rmw_addr_q;
            ram_we_w    = 1'b1;
            ram_wdata_w = rmw_data_q;
        end else if (cpu_gnt_w) begin
            ram_addr_w = bus.cpu_addr;
            if (cpu_full_wr) begin
                ram_we_w    = 1'b1;
                ram_wdata_w = bus.cpu_wdata;
            end
        end else if (ppu_gnt_w) begin
            ram_addr_w = bus.ppu_addr;
        end
    end

    // Arbiter FSM with registered read returns and RMW capture
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q      <= IDLE;
            rmw_addr_q   <= '0;
            rmw_data_q   <= 32'd0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= 32'd0;
            ppu_rvalid_q <= 1'b0;
            ppu_rdata_q  <= 32'd0;
        end else begin
            cpu_rvalid_q <= cpu_rd;
            ppu_rvalid_q <= ppu_gnt_w;
            if (cpu_rd) begin
                cpu_rdata_q <= bus.ram_rdata;
            end
            if (ppu_gnt_w) begin
                ppu_rdata_q <= bus.ram_rdata;
            end
            case (state_q)
                IDLE: begin
                    if (cpu_half_wr) begin
                        rmw_addr_q <= bus.cpu_addr;
                        rmw_data_q <= merge_half(bus.ram_rdata, bus.cpu_wdata, bus.cpu_be);
                        state_q    <= RMW_WR;
                    end
                end
                RMW_WR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_gnt    = cpu_gnt_w;
    assign bus.ppu_gnt    = ppu_gnt_w;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.ppu_rvalid = ppu_rvalid_q;
    assign bus.ppu_rdata  = ppu_rdata_q;
    assign bus.ram_addr   = ram_addr_w;
    assign bus.ram_we     = ram_we_w;
    assign bus.ram_wdata  = ram_wdata_w;

`ifdef OAM_ARB_STATS_EN
    logic [15:0] stall_cnt_q;

    // CPU stall statistics: saturating, synchronously clearable
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            stall_cnt_q <= 16'd0;
        end else if (stats_clr) begin
            stall_cnt_q <= 16'd0;
        end else if (cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign cpu_stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_oam_arbiter.sv
// ============================================================================
// Module      : tb_oam_arbiter
// Description : Directed self-checking bench for oam_arbiter with a behavioural
//               asynchronous-read OAM RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oam_arbiter;

    logic        clka   = 1'b0;
    logic        rsta_n = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          we_count = 0;
    int          snap;

    logic [31:0] mem [0:255];
    logic        pre_en   = 1'b0;
    logic [7:0]  pre_addr = 8'd0;
    logic [31:0] pre_data = 32'd0;

`ifdef OAM_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] stall_cnt;
`endif

    oam_arbiter_if #(.ADDR_W(8)) bus ();

    oam_arbiter #(
        .ADDR_W     (8),
        .STARVE_MAX (4)
    ) dut (
        .clka          (clka),
        .rsta_n        (rsta_n),
`ifdef OAM_ARB_STATS_EN
        .stats_clr     (stats_clr),
        .cpu_stall_cnt (stall_cnt),
`endif
        .bus           (bus)
    );

    always #5 clka = ~clka;

    // Behavioural OAM: asynchronous read, synchronous write, preload port
    assign bus.ram_rdata = mem[bus.ram_addr];

    always @(posedge clka) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.ram_we === 1'b1) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
            we_count <= we_count + 1;
        end
    end

    task automatic cyc();
        @(posedge clka);
        #1;
    endtask

    task automatic idle_bus();
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = 8'd0;
        bus.cpu_be     = 4'h0;
        bus.cpu_wdata  = 32'd0;
        bus.ppu_req    = 1'b0;
        bus.ppu_addr   = 8'd0;
        bus.ppu_active = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        cyc();
        pre_en   = 1'b0;
    endtask

    task automatic cpu_drive(input logic we, input logic [7:0] a,
                             input logic [3:0] be, input logic [31:0] d);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_be    = be;
        bus.cpu_wdata = d;
    endtask

    task automatic test_reset();
        idle_bus();
        rsta_n = 1'b0;
        cyc();
        cyc();
        n_tests++;
        if ({bus.cpu_gnt, bus.ppu_gnt, bus.cpu_rvalid, bus.ppu_rvalid, bus.ram_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got gnt/rv/we=%b want 00000",
                     {bus.cpu_gnt, bus.ppu_gnt, bus.cpu_rvalid, bus.ppu_rvalid, bus.ram_we});
        end
        n_tests++;
        if (bus.cpu_rdata !== 32'd0 || bus.ppu_rdata !== 32'd0 ||
            bus.ram_addr !== 8'd0 || bus.ram_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: cpu_rdata=%h ppu_rdata=%h ram_addr=%h ram_wdata=%h want all 0",
                     bus.cpu_rdata, bus.ppu_rdata, bus.ram_addr, bus.ram_wdata);
        end
        rsta_n = 1'b1;
        cyc();
    endtask

    task automatic test_cpu_read();
        preload(8'h10, 32'hDEADBEEF);
        cpu_drive(1'b0, 8'h10, 4'h0, 32'd0);
        #1;
        n_tests++;
        if (bus.cpu_gnt !== 1'b1 || bus.ppu_gnt !== 1'b0 || bus.ram_addr !== 8'h10) begin
            n_fail++;
            $display("FAIL rd_gnt: cpu_gnt=%b ppu_gnt=%b ram_addr=%h want 1 0 10",
                     bus.cpu_gnt, bus.ppu_gnt, bus.ram_addr);
        end
        cyc();
        bus.cpu_req = 1'b0;
        #1;
        n_tests++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_data: rvalid=%b rdata=%h want 1 deadbeef", bus.cpu_rvalid, bus.cpu_rdata);
        end
        cyc();
        n_tests++;
        if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_hold: rvalid=%b rdata=%h want 0 deadbeef", bus.cpu_rvalid, bus.cpu_rdata);
        end
    endtask

    task automatic test_full_write();
        cpu_drive(1'b1, 8'h40, 4'hF, 32'h1234_5678);
        #1;
        n_tests++;
        if (bus.cpu_gnt !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_wdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL full_wr: gnt=%b we=%b wdata=%h want 1 1 12345678",
                     bus.cpu_gnt, bus.ram_we, bus.ram_wdata);
        end
        cyc();
        bus.cpu_req = 1'b0;
        #1;
        n_tests++;
        if (mem[8'h40] !== 32'h1234_5678 || bus.cpu_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_wr_mem: mem=%h rvalid=%b want 12345678 0", mem[8'h40], bus.cpu_rvalid);
        end
    endtask

    task automatic test_halfword_lo();
        preload(8'h20, 32'hAAAA_BBBB);
        cpu_drive(1'b1, 8'h20, 4'h3, 32'h0000_1234);
        bus.ppu_req  = 1'b1;
        bus.ppu_addr = 8'h20;
        #1;
        n_tests++;
        if (bus.cpu_gnt !== 1'b1 || bus.ppu_gnt !== 1'b0 || bus.ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw_grant: cpu_gnt=%b ppu_gnt=%b we=%b want 1 0 0",
                     bus.cpu_gnt, bus.ppu_gnt, bus.ram_we);
        end
        cyc();
        bus.cpu_req = 1'b0;
        #1;
        n_tests++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h20 || bus.ram_wdata !== 32'hAAAA_1234 ||
            bus.ppu_gnt !== 1'b0 || bus.cpu_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw_wr: we=%b addr=%h wdata=%h ppu_gnt=%b cpu_gnt=%b want 1 20 aaaa1234 0 0",
                     bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.ppu_gnt, bus.cpu_gnt);
        end
        cyc();
        n_tests++;
        if (mem[8'h20] !== 32'hAAAA_1234 || bus.ppu_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rmw_mem: mem=%h ppu_gnt=%b want aaaa1234 1", mem[8'h20], bus.ppu_gnt);
        end
        cyc();
        bus.ppu_req = 1'b0;
        #1;
        n_tests++;
        if (bus.ppu_rvalid !== 1'b1 || bus.ppu_rdata !== 32'hAAAA_1234) begin
            n_fail++;
            $display("FAIL rmw_ppu_rd: rvalid=%b rdata=%h want 1 aaaa1234", bus.ppu_rvalid, bus.ppu_rdata);
        end
    endtask

    task automatic test_halfword_hi_stall();
        preload(8'h21, 32'h1111_2222);
        cpu_drive(1'b1, 8'h21, 4'hC, 32'h5678_0000);
        #1;
        cyc();
        cpu_drive(1'b0, 8'h21, 4'h0, 32'd0);
        bus.ppu_req    = 1'b1;
        bus.ppu_addr   = 8'h00;
        bus.ppu_active = 1'b1;
        #1;
        n_tests++;
        if (bus.cpu_gnt !== 1'b0 || bus.ppu_gnt !== 1'b0 || bus.ram_we !== 1'b1 ||
            bus.ram_wdata !== 32'h5678_2222) begin
            n_fail++;
            $display("FAIL rmw_stall: cpu_gnt=%b ppu_gnt=%b we=%b wdata=%h want 0 0 1 56782222",
                     bus.cpu_gnt, bus.ppu_gnt, bus.ram_we, bus.ram_wdata);
        end
        cyc();
        bus.ppu_active = 1'b0;
        #1;
        n_tests++;
        if (bus.cpu_gnt !== 1'b1 || bus.ppu_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_resume: cpu_gnt=%b ppu_gnt=%b want 1 0", bus.cpu_gnt, bus.ppu_gnt);
        end
        cyc();
        idle_bus();
        #1;
        n_tests++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h5678_2222) begin
            n_fail++;
            $display("FAIL hi_merge_rd: rvalid=%b rdata=%h want 1 56782222", bus.cpu_rvalid, bus.cpu_rdata);
        end
    endtask

    task automatic test_byte_drop();
        preload(8'h30, 32'hCAFE_F00D);
        snap = we_count;
        cpu_drive(1'b1, 8'h30, 4'h1, 32'h0000_0000);
        #1;
        n_tests++;
        if (bus.cpu_gnt !== 1'b1 || bus.ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_gnt: gnt=%b we=%b want 1 0", bus.cpu_gnt, bus.ram_we);
        end
        cyc();
        bus.cpu_req = 1'b0;
        #1;
        n_tests++;
        if (bus.ram_we !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_next: we=%b rvalid=%b want 0 0", bus.ram_we, bus.cpu_rvalid);
        end
        cyc();
        cyc();
        n_tests++;
        if (we_count !== snap || mem[8'h30] !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL drop_mem: writes=%0d mem=%h want %0d cafef00d", we_count, mem[8'h30], snap);
        end
    endtask

    task automatic test_starvation();
        cpu_drive(1'b0, 8'h40, 4'h0, 32'd0);
        bus.ppu_req    = 1'b1;
        bus.ppu_addr   = 8'h10;
        bus.ppu_active = 1'b1;
        #1;
        for (int i = 1; i <= 4; i++) begin
            n_tests++;
            if (bus.cpu_gnt !== 1'b0 || bus.ppu_gnt !== 1'b1) begin
                n_fail++;
                $display("FAIL starve_c%0d: cpu_gnt=%b ppu_gnt=%b want 0 1", i, bus.cpu_gnt, bus.ppu_gnt);
            end
            if (i == 2) begin
                n_tests++;
                if (bus.ppu_rvalid !== 1'b1 || bus.ppu_rdata !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL ppu_rd: rvalid=%b rdata=%h want 1 deadbeef", bus.ppu_rvalid, bus.ppu_rdata);
                end
            end
            cyc();
        end
        n_tests++;
        if (bus.cpu_gnt !== 1'b1 || bus.ppu_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_c5: cpu_gnt=%b ppu_gnt=%b want 1 0", bus.cpu_gnt, bus.ppu_gnt);
        end
        cyc();
        bus.cpu_req = 1'b0;
        #1;
        n_tests++;
        if (bus.ppu_gnt !== 1'b1 || bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h1234_5678 ||
            bus.ppu_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_after: ppu_gnt=%b cpu_rv=%b cpu_rdata=%h ppu_rv=%b want 1 1 12345678 0",
                     bus.ppu_gnt, bus.cpu_rvalid, bus.cpu_rdata, bus.ppu_rvalid);
        end
        cyc();
        idle_bus();
        cyc();
    endtask

    task automatic test_blank_priority();
        cpu_drive(1'b0, 8'h10, 4'h0, 32'd0);
        bus.ppu_req    = 1'b1;
        bus.ppu_addr   = 8'h21;
        bus.ppu_active = 1'b0;
        #1;
        n_tests++;
        if (bus.cpu_gnt !== 1'b1 || bus.ppu_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_c1: cpu_gnt=%b ppu_gnt=%b want 1 0", bus.cpu_gnt, bus.ppu_gnt);
        end
        cyc();
        bus.cpu_req = 1'b0;
        #1;
        n_tests++;
        if (bus.ppu_gnt !== 1'b1 || bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL blank_c2: ppu_gnt=%b cpu_rv=%b cpu_rdata=%h want 1 1 deadbeef",
                     bus.ppu_gnt, bus.cpu_rvalid, bus.cpu_rdata);
        end
        cyc();
        idle_bus();
        #1;
        n_tests++;
        if (bus.ppu_rvalid !== 1'b1 || bus.ppu_rdata !== 32'h5678_2222) begin
            n_fail++;
            $display("FAIL blank_ppu_rd: rvalid=%b rdata=%h want 1 56782222", bus.ppu_rvalid, bus.ppu_rdata);
        end
        cyc();
    endtask

    task automatic test_reset_mid_rmw();
        preload(8'h50, 32'h0BAD_F00D);
        snap = we_count;
        cpu_drive(1'b1, 8'h50, 4'h3, 32'hFFFF_0000);
        #1;
        cyc();
        idle_bus();
        rsta_n = 1'b0;
        #1;
        n_tests++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 8'd0 || bus.ram_wdata !== 32'd0 ||
            bus.cpu_gnt !== 1'b0 || bus.ppu_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rmw_port: we=%b addr=%h wdata=%h cpu_gnt=%b ppu_gnt=%b want all 0",
                     bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.cpu_gnt, bus.ppu_gnt);
        end
        n_tests++;
        if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'd0 || bus.ppu_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_rmw_out: cpu_rv=%b cpu_rdata=%h ppu_rdata=%h want 0 0 0",
                     bus.cpu_rvalid, bus.cpu_rdata, bus.ppu_rdata);
        end
        cyc();
        cyc();
        n_tests++;
        if (we_count !== snap || mem[8'h50] !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL rst_rmw_mem: writes=%0d mem=%h want %0d 0badf00d", we_count, mem[8'h50], snap);
        end
        rsta_n = 1'b1;
        cyc();
        cpu_drive(1'b0, 8'h50, 4'h0, 32'd0);
        cyc();
        idle_bus();
        #1;
        n_tests++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL rst_rmw_rd: rvalid=%b rdata=%h want 1 0badf00d", bus.cpu_rvalid, bus.cpu_rdata);
        end
        cyc();
    endtask

    initial begin
        idle_bus();
        test_reset();
        test_cpu_read();
        test_full_write();
        test_halfword_lo();
        test_halfword_hi_stall();
        test_byte_drop();
        test_starvation();
        test_blank_priority();
        test_reset_mid_rmw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
